// File: rtl/row_conv_pipe.sv
// Purpose: K-tap 1-D fixed-point row convolution with bias, saturation and row framing.
// Latency: out_valid rises 2 unstalled cycles after the producing sample is accepted.
// Backpressure: a stalled output (out_valid && !out_ready) freezes window, counter and both stages.
module row_conv_pipe #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int K       = 5,
  parameter int ROW_LEN = 28
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_load,
  input  logic [K*DATA_W-1:0] weight,
  input  logic [DATA_W-1:0]   bias,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_sol,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                sat_flag
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int GUARD  = $clog2(K) + 1;
  localparam int ACC_W  = PROD_W + GUARD;
  localparam int COL_W  = $clog2(ROW_LEN);

  // Signed result limits, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] w_q    [K];
  logic signed [DATA_W-1:0] bias_q;
  logic signed [DATA_W-1:0] win_q  [K];
  logic signed [DATA_W-1:0] win_d  [K];
  logic [COL_W-1:0]         col_q, col_d, col_eff;
  logic signed [PROD_W-1:0] prod_q [K];
  logic signed [PROD_W-1:0] prod_d [K];
  logic                     s1_vld_q, s1_last_q;
  logic [DATA_W-1:0]        out_data_q, res_d;
  logic                     out_vld_q, out_last_q, sat_q, sat_d;
  logic signed [ACC_W-1:0]  acc, shifted;
  logic                     accept, produce_d, last_d;

  // The whole pipe advances only when the output register is free to move.
  assign in_ready = !(out_vld_q && !out_ready);
  assign accept   = in_valid && in_ready;

  // A start-of-line sample is column 0 no matter where the counter stood.
  assign col_eff   = in_sol ? '0 : col_q;
  assign col_d     = (col_eff == COL_W'(ROW_LEN-1)) ? '0 : col_eff + 1'b1;
  assign produce_d = accept && (col_eff >= COL_W'(K-1));
  assign last_d    = accept && (col_eff == COL_W'(ROW_LEN-1));

  // Shifted window (newest at tap K-1) and its products against the held taps.
  always_comb begin
    for (int i = 0; i < K-1; i++) win_d[i] = win_q[i+1];
    win_d[K-1] = in_data;
    for (int i = 0; i < K; i++) prod_d[i] = PROD_W'(win_d[i]) * PROD_W'(w_q[i]);
  end

  // Sum of products plus aligned bias, floor-shift back to the result scale, then clamp.
  always_comb begin
    acc = ACC_W'(bias_q) <<< FRAC_W;
    for (int i = 0; i < K; i++) acc = acc + ACC_W'(prod_q[i]);
    shifted = acc >>> FRAC_W;
    sat_d   = 1'b0;
    res_d   = shifted[DATA_W-1:0];
    if (shifted > MAX_V) begin
      res_d = MAX_V[DATA_W-1:0];
      sat_d = 1'b1;
    end else if (shifted < MIN_V) begin
      res_d = MIN_V[DATA_W-1:0];
      sat_d = 1'b1;
    end
  end

  // Coefficient capture ignores stalls; a same-cycle sample still sees the old taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) w_q[i] <= '0;
      bias_q <= '0;
    end else if (w_load) begin
      for (int i = 0; i < K; i++) w_q[i] <= weight[(K-i)*DATA_W-1 -: DATA_W];
      bias_q <= bias;
    end
  end

  // Sample window and column counter move only on an accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) win_q[i] <= '0;
      col_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < K; i++) win_q[i] <= win_d[i];
      col_q <= col_d;
    end
  end

  // Two-stage datapath: products, then the clamped result with its framing bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) prod_q[i] <= '0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
    end else if (in_ready) begin
      if (accept) begin
        for (int i = 0; i < K; i++) prod_q[i] <= prod_d[i];
      end
      s1_vld_q   <= produce_d;
      s1_last_q  <= last_d;
      out_vld_q  <= s1_vld_q;
      out_last_q <= s1_vld_q && s1_last_q;
      if (s1_vld_q) out_data_q <= res_d;
    end
  end

  // Saturation indicator is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else if (in_ready && s1_vld_q && sat_d) sat_q <= 1'b1;
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sat_flag  = sat_q;

endmodule
